// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: operand width, multiplier FSM states,
// and the magnitude helper used by the iterative arithmetic blocks.
package calc_pkg;

  localparam int CALC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

  // Most negative value maps to 2^(CALC_WIDTH-1), which still fits unsigned.
  function automatic logic [CALC_WIDTH-1:0] abs_mag(input logic [CALC_WIDTH-1:0] v);
    return v[CALC_WIDTH-1] ? (-v) : v;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative signed shift-and-add multiplier, one product bit per clock.
// Fixed latency: mul_finish pulses WIDTH+1 cycles after the accepting edge; start_mul is ignored while busy.
module shift_add_mul
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic [WIDTH-1:0] mul_in1,
  input  logic [WIDTH-1:0] mul_in2,
  output logic [WIDTH-1:0] mul_out,
  output logic             mul_finish,
  output logic             mul_ovf,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  mul_state_t          r_state;
  mul_state_t          w_next_state;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_neg;
  logic [2*WIDTH-1:0]  r_acc;
  logic [CNTW-1:0]     r_cnt;
  logic [WIDTH-1:0]    r_out;
  logic                r_ovf;
  logic                r_finish;
  logic                r_busy;

  logic                w_accept;
  logic                w_last_iter;
  logic [2*WIDTH-1:0]  w_addend;
  logic [2*WIDTH-1:0]  w_product;
  logic [WIDTH:0]      w_top;

  assign w_accept    = (r_state == IDLE) && start_mul;
  assign w_last_iter = (r_cnt == CNTW'(WIDTH - 1));
  assign w_addend    = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_product   = r_neg ? (-r_acc) : r_acc;
  // The product fits in WIDTH signed bits only if its upper half plus sign bit agree.
  assign w_top       = w_product[2*WIDTH-1:WIDTH-1];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start_mul) w_next_state = CALC;
      CALC:    if (w_last_iter) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_finish <= 1'b0;
      r_busy   <= w_accept || (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (start_mul) begin
            r_mcand  <= abs_mag(mul_in1);
            r_mplier <= abs_mag(mul_in2);
            r_neg    <= mul_in1[WIDTH-1] ^ mul_in2[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + w_addend;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNTW'(1);
        end
        DONE: begin
          r_out    <= w_product[WIDTH-1:0];
          r_ovf    <= !((w_top == '0) || (w_top == '1));
          r_finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mul_out    = r_out;
  assign mul_ovf    = r_ovf;
  assign mul_finish = r_finish;
  assign busy       = r_busy;

endmodule
